multi_port_mem_arbiter: RTL
===========================

// Module: multi_port_mem_arbiter
// PURPOSE
//  Shares one external memory port among NUM_PORTS core memory ports.
//  Each upstream port sees the same serial-tagged read/write protocol a single core drives into memory.
//  Read requests get a serial from a per-port counter; write requests get a write serial the same way.
//  Downstream serials are translated back through tag tables, and each response goes to the port that issued the request.
//  The block sits between the core instances and the shared memory controller.
// PARAMETERS
//  NUM_PORTS   2    upstream core ports (>=2); PORT_W = $clog2(NUM_PORTS)
//  ADDR_W      32   physical address width
//  DATA_W      128  memory entry (line) width
//  RSERIAL_W   4    read serial width; read table depth 2**RSERIAL_W
//  WSERIAL_W   4    write serial width; write table depth 2**WSERIAL_W
// PORTS
//  clk              in   1                    clock
//  rst              in   1                    async reset, active-low (0 = reset)
//  upAddr           in   NUM_PORTS*ADDR_W     per-port request address
//  upWriteData      in   NUM_PORTS*DATA_W     per-port write data
//  upRE             in   NUM_PORTS            per-port read request
//  upWE             in   NUM_PORTS            per-port write request
//  upReadBusy       out  NUM_PORTS            read not accepted this cycle
//  upWriteBusy      out  NUM_PORTS            write not accepted this cycle
//  upNextReadSerial out  NUM_PORTS*RSERIAL_W  serial for the port's next read
//  upNextWriteSerial out NUM_PORTS*WSERIAL_W  serial for the port's next write
//  upReadDataReady  out  NUM_PORTS            read data valid (1-cycle pulse)
//  upReadData       out  DATA_W               read data (shared bus, qualified by ready)
//  upReadSerial     out  RSERIAL_W            port-local serial of the returned read
//  upWriteAck       out  NUM_PORTS            write complete (1-cycle pulse)
//  upWriteAckSerial out  WSERIAL_W            port-local serial of the completed write
//  memAddr/memWriteData/memRE/memWE  out  ADDR_W/DATA_W/1/1  downstream request
//  memReadBusy, memWriteBusy         in   1   downstream busy
//  memNextReadSerial   in  RSERIAL_W  downstream serial for the next read
//  memNextWriteSerial  in  WSERIAL_W  downstream serial for the next write
//  memReadDataReady    in  1          downstream read data valid
//  memReadData         in  DATA_W     downstream read data
//  memReadSerial       in  RSERIAL_W  downstream serial of that read data
//  memWriteAckValid    in  1          downstream write complete
//  memWriteAckSerial   in  WSERIAL_W  downstream serial of that write
//  tagError         out  1                    sticky: response hit an invalid table entry
// BEHAVIOUR
//  - Request acceptance
//    - A port requests when upRE|upWE is high; RE and WE together on one port is illegal (bench asserts).
//    - Round-robin arbiter with pointer rrPtr: grants the first requesting port at or after rrPtr,
//      skipping ports whose request is blocked.
//    - At most one grant per cycle.
//    - After a grant, rrPtr <= grant+1 (mod NUM_PORTS).
//    - A request is blocked when any of these holds:
//      - read: memReadBusy, or readTable[memNextReadSerial].valid;
//      - write: memWriteBusy, or writeTable[memNextWriteSerial].valid.
//    - upReadBusy[i]/upWriteBusy[i] = !(granted[i]); combinational, same cycle.
//    - The request is accepted iff it is asserted and busy is low. The port holds its request while busy.
//    - memAddr/memWriteData/memRE/memWE are driven combinationally from the granted port; 0 when there is no grant.
//  - Serials and tag tables
//    - Per-port counters nextRS[i] and nextWS[i] are incremented on the port's accepted read or write.
//      They wrap modulo 2**RSERIAL_W and 2**WSERIAL_W.
//    - Accepted read: readTable[memNextReadSerial] <= {valid=1, port, nextRS[port]}.
//    - Accepted write: writeTable[memNextWriteSerial] <= {valid=1, port, nextWS[port]}.
//    - Table valid bits used for blocking are the registered values.
//      An entry freed by a response in cycle t is reusable from t+1.
//  - Responses (1-cycle registered latency)
//    - memReadDataReady with memReadSerial=s and readTable[s] valid:
//      - at the next edge, upReadDataReady[port]=1, upReadData=memReadData, upReadSerial=entry serial;
//      - the entry is invalidated.
//    - Write acks follow the same rule using writeTable and upWriteAck/upWriteAckSerial.
//    - A read response and a write ack in the same cycle are both delivered; they may target the same port.
//    - A response to an invalid entry is dropped, no upstream pulse is generated, and tagError is set
//      (cleared only by reset).
//  - Reset
//    - Asynchronous, active-low, may assert mid-transaction.
//    - All counters, rrPtr, table valid bits, response outputs and tagError go to 0.
//    - All busy outputs are forced to 1 while rst is low; in-flight downstream responses after reset are tag errors.
// TESTING
//  1. Reset, then port0 read to 0x1000 with memNextReadSerial=3; mem returns serial 3, data 0xAB.
//     -> next cycle upReadDataReady=01, upReadData=0xAB, upReadSerial=0.
//  2. Both ports request reads every cycle, no busy.
//     -> grants alternate 0,1,0,1.
//     -> each port's upNextReadSerial advances 1 per grant and wraps 15->0.
//  3. Fill 16 reads without responses.
//     -> 17th read is busy; one response frees the entry; reissue is accepted the cycle after.
//  4. Port1 write (ack serial 5) and port0 read response arrive in the same cycle.
//     -> upWriteAck=10 and upReadDataReady=01 both appear the next cycle.
//  5. memReadSerial=7 with the entry invalid.
//     -> no upReadDataReady; tagError=1 and stays 1 until reset.
//  6. Assert rst=0 with 4 reads outstanding.
//     -> all outputs 0 and busy=all 1s; after release, serials restart at 0.

Source files
------------

// File: rtl/multi_port_mem_arbiter.sv
// Round-robin sharing of one serial-tagged memory port among NUM_PORTS cores.
// Downstream serials are mapped back to the issuing port and its local serial via tag tables.
module multi_port_mem_arbiter #(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 128,
    parameter int RSERIAL_W = 4,
    parameter int WSERIAL_W = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_PORTS*ADDR_W-1:0]    upAddr,
    input  logic [NUM_PORTS*DATA_W-1:0]    upWriteData,
    input  logic [NUM_PORTS-1:0]           upRE,
    input  logic [NUM_PORTS-1:0]           upWE,
    output logic [NUM_PORTS-1:0]           upReadBusy,
    output logic [NUM_PORTS-1:0]           upWriteBusy,
    output logic [NUM_PORTS*RSERIAL_W-1:0] upNextReadSerial,
    output logic [NUM_PORTS*WSERIAL_W-1:0] upNextWriteSerial,
    output logic [NUM_PORTS-1:0]           upReadDataReady,
    output logic [DATA_W-1:0]              upReadData,
    output logic [RSERIAL_W-1:0]           upReadSerial,
    output logic [NUM_PORTS-1:0]           upWriteAck,
    output logic [WSERIAL_W-1:0]           upWriteAckSerial,
    output logic [ADDR_W-1:0]              memAddr,
    output logic [DATA_W-1:0]              memWriteData,
    output logic                           memRE,
    output logic                           memWE,
    input  logic                           memReadBusy,
    input  logic                           memWriteBusy,
    input  logic [RSERIAL_W-1:0]           memNextReadSerial,
    input  logic [WSERIAL_W-1:0]           memNextWriteSerial,
    input  logic                           memReadDataReady,
    input  logic [DATA_W-1:0]              memReadData,
    input  logic [RSERIAL_W-1:0]           memReadSerial,
    input  logic                           memWriteAckValid,
    input  logic [WSERIAL_W-1:0]           memWriteAckSerial,
    output logic                           tagError
);
    localparam int PORT_W = $clog2(NUM_PORTS);
    localparam int RDEPTH = 2 ** RSERIAL_W;
    localparam int WDEPTH = 2 ** WSERIAL_W;

    logic [PORT_W-1:0]    rrPtr_q;
    logic [RSERIAL_W-1:0] nextRS_q [NUM_PORTS];
    logic [WSERIAL_W-1:0] nextWS_q [NUM_PORTS];

    logic [RDEPTH-1:0]    rtValid_q, rtValid_d;
    logic [PORT_W-1:0]    rtPort_q   [RDEPTH];
    logic [RSERIAL_W-1:0] rtSerial_q [RDEPTH];
    logic [WDEPTH-1:0]    wtValid_q, wtValid_d;
    logic [PORT_W-1:0]    wtPort_q   [WDEPTH];
    logic [WSERIAL_W-1:0] wtSerial_q [WDEPTH];

    logic [NUM_PORTS-1:0] rdRdy_q, rdRdy_d, wrAck_q, wrAck_d;
    logic [DATA_W-1:0]    rdData_q;
    logic [RSERIAL_W-1:0] rdSer_q;
    logic [WSERIAL_W-1:0] wrSer_q;
    logic                 tagError_q, tagError_d;

    logic                 rdBlocked, wrBlocked, grantVld, acceptRd, acceptWr, rdHit, wrHit;
    logic [NUM_PORTS-1:0] eligible, grant;
    logic [PORT_W-1:0]    grantIdx;

    always_comb begin
        int idx;
        idx       = 0;
        rdBlocked = memReadBusy | rtValid_q[memNextReadSerial];
        wrBlocked = memWriteBusy | wtValid_q[memNextWriteSerial];
        eligible  = '0;
        grantVld  = 1'b0;
        grantIdx  = '0;
        for (int i = 0; i < NUM_PORTS; i++)
            eligible[i] = upRE[i] ? ~rdBlocked : (upWE[i] & ~wrBlocked);
        // Nothing is granted while reset is held, so every port reports busy.
        if (rst) begin
            for (int k = 0; k < NUM_PORTS; k++) begin
                idx = (int'(rrPtr_q) + k) % NUM_PORTS;
                if (!grantVld && eligible[idx]) begin
                    grantVld = 1'b1;
                    grantIdx = PORT_W'(idx);
                end
            end
        end
    end

    assign grant       = grantVld ? (NUM_PORTS'(1) << grantIdx) : '0;
    assign upReadBusy  = ~grant;
    assign upWriteBusy = ~grant;
    assign acceptRd    = grantVld & upRE[grantIdx];
    assign acceptWr    = grantVld & ~upRE[grantIdx] & upWE[grantIdx];
    assign memRE       = acceptRd;
    assign memWE       = acceptWr;

    always_comb begin
        memAddr      = '0;
        memWriteData = '0;
        if (grantVld) begin
            memAddr      = upAddr[int'(grantIdx)*ADDR_W +: ADDR_W];
            memWriteData = upWriteData[int'(grantIdx)*DATA_W +: DATA_W];
        end
        for (int i = 0; i < NUM_PORTS; i++) begin
            upNextReadSerial[i*RSERIAL_W +: RSERIAL_W]  = nextRS_q[i];
            upNextWriteSerial[i*WSERIAL_W +: WSERIAL_W] = nextWS_q[i];
        end
    end

    // Free before allocate: an accept never targets a valid entry, so the two indices differ.
    always_comb begin
        rdHit      = memReadDataReady & rtValid_q[memReadSerial];
        wrHit      = memWriteAckValid & wtValid_q[memWriteAckSerial];
        rdRdy_d    = '0;
        wrAck_d    = '0;
        rtValid_d  = rtValid_q;
        wtValid_d  = wtValid_q;
        tagError_d = tagError_q | (memReadDataReady & ~rtValid_q[memReadSerial])
                                | (memWriteAckValid & ~wtValid_q[memWriteAckSerial]);
        if (rdHit) begin
            rdRdy_d[rtPort_q[memReadSerial]] = 1'b1;
            rtValid_d[memReadSerial]         = 1'b0;
        end
        if (wrHit) begin
            wrAck_d[wtPort_q[memWriteAckSerial]] = 1'b1;
            wtValid_d[memWriteAckSerial]         = 1'b0;
        end
        if (acceptRd) rtValid_d[memNextReadSerial]  = 1'b1;
        if (acceptWr) wtValid_d[memNextWriteSerial] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rrPtr_q    <= '0;
            rtValid_q  <= '0;
            wtValid_q  <= '0;
            rdRdy_q    <= '0;
            wrAck_q    <= '0;
            rdData_q   <= '0;
            rdSer_q    <= '0;
            wrSer_q    <= '0;
            tagError_q <= 1'b0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                nextRS_q[i] <= '0;
                nextWS_q[i] <= '0;
            end
        end else begin
            if (grantVld)
                rrPtr_q <= (grantIdx == PORT_W'(NUM_PORTS - 1)) ? '0 : grantIdx + PORT_W'(1);
            if (acceptRd) nextRS_q[grantIdx] <= nextRS_q[grantIdx] + RSERIAL_W'(1);
            if (acceptWr) nextWS_q[grantIdx] <= nextWS_q[grantIdx] + WSERIAL_W'(1);
            rtValid_q  <= rtValid_d;
            wtValid_q  <= wtValid_d;
            rdRdy_q    <= rdRdy_d;
            wrAck_q    <= wrAck_d;
            tagError_q <= tagError_d;
            if (rdHit) begin
                rdData_q <= memReadData;
                rdSer_q  <= rtSerial_q[memReadSerial];
            end
            if (wrHit) wrSer_q <= wtSerial_q[memWriteAckSerial];
        end
    end

    // Table payload is only meaningful under its valid bit, so it needs no reset.
    always_ff @(posedge clk) begin
        if (acceptRd) begin
            rtPort_q[memNextReadSerial]   <= grantIdx;
            rtSerial_q[memNextReadSerial] <= nextRS_q[grantIdx];
        end
        if (acceptWr) begin
            wtPort_q[memNextWriteSerial]   <= grantIdx;
            wtSerial_q[memNextWriteSerial] <= nextWS_q[grantIdx];
        end
    end

    assign upReadDataReady  = rdRdy_q;
    assign upReadData       = rdData_q;
    assign upReadSerial     = rdSer_q;
    assign upWriteAck       = wrAck_q;
    assign upWriteAckSerial = wrSer_q;
    assign tagError         = tagError_q;

endmodule
